conv_window: RTL and testbench

//  Sliding-window generator feeding the convolution datapath's FSIZE x FSIZE pixel port.

---
 rtl/conv_window_pkg.sv | 24 ++
 rtl/conv_linebuf_row.sv | 44 ++++
 rtl/conv_window.sv | 210 +++++++++++++++++++++
 tb/tb_conv_window.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_pkg.sv
// Shared definitions for the conv_window sliding-window generator.
//   DWIDTH / FSIZE / MAXW / LWIDTH : default pixel width, filter edge (3 or 5),
//                                    maximum feature-map edge, counter width
//   state_t                        : frame FSM states
//   addr_width()                   : address width for a given depth (minimum 1)
package conv_window_pkg;

  localparam int unsigned DWIDTH = 16;
  localparam int unsigned FSIZE  = 5;
  localparam int unsigned MAXW   = 32;
  localparam int unsigned LWIDTH = 6;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream,
    StDone
  } state_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_linebuf_row.sv
// One row buffer of the window generator: single-port DataWidth x Depth RAM.
//   clk, xrst : clock, asynchronous active-high reset (read register only)
//   en_i      : port access this cycle
//   we_i      : write wdata_i at addr_i (only with en_i)
//   addr_i    : column address
//   wdata_i   : write data
//   rdata_o   : registered read data; returns the pre-write contents of addr_i
module conv_linebuf_row #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 xrst,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  // Storage is deliberately not reset; only rows written in the current frame ever
  // reach a valid window.
  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read-before-write: same-address write in this cycle is not forwarded.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_window.sv
// Sliding-window generator: turns a raster-order square feature map into stride-1
// FilterSize x FilterSize windows for the convolution datapath (no padding).
//   clk, xrst    : clock, asynchronous active-high reset
//   buf_start    : frame start pulse; img_size sampled when accepted in idle
//   img_size     : frame edge, legal range FilterSize..MaxWidth
//   pixel_valid  : pixel_in valid (accepted only while filling/streaming)
//   pixel_in     : raster-order pixel
//   pixel_out    : window, element [i*FilterSize+j] = row r-F+1+i, column c-F+1+j
//   window_valid : pixel_out holds a new complete window
//   frame_done   : one-cycle pulse after the last pixel of the frame
//   size_err     : one-cycle pulse after a rejected buf_start
//   busy         : frame in progress
// Optional build macro CONV_WINDOW_STRIDE2_EN: only windows at even row/column
// offsets from the first window are flagged valid (pixel_out still updates).
module conv_window
  import conv_window_pkg::*;
#(
  parameter int unsigned DataWidth  = DWIDTH,
  parameter int unsigned FilterSize = FSIZE,
  parameter int unsigned MaxWidth   = MAXW,
  parameter int unsigned CntWidth   = LWIDTH
) (
  input  logic                                           clk,
  input  logic                                           xrst,
  input  logic                                           buf_start,
  input  logic [CntWidth-1:0]                            img_size,
  input  logic                                           pixel_valid,
  input  logic [DataWidth-1:0]                           pixel_in,
  output logic [FilterSize*FilterSize-1:0][DataWidth-1:0] pixel_out,
  output logic                                           window_valid,
  output logic                                           frame_done,
  output logic                                           size_err,
  output logic                                           busy
);

  localparam int unsigned NumBuf    = FilterSize - 1;
  localparam int unsigned AddrWidth = addr_width(MaxWidth);
  localparam int unsigned SelWidth  = addr_width(NumBuf);

  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
  localparam logic [CntWidth-1:0] MinSize  = CntWidth'(FilterSize);
  localparam logic [CntWidth-1:0] MaxSize  = CntWidth'(MaxWidth);
  localparam logic [CntWidth-1:0] FirstWin = CntWidth'(FilterSize - 1);
  localparam logic [CntWidth-1:0] FillEnd  = CntWidth'(FilterSize - 2);
  localparam logic [SelWidth-1:0] SelOne   = SelWidth'(1);
  localparam logic [SelWidth-1:0] SelLast  = SelWidth'(NumBuf - 1);

  state_t state_q, state_d;

  logic [CntWidth-1:0] size_q, size_d;
  logic [CntWidth-1:0] row_q, row_d;
  logic [CntWidth-1:0] col_q, col_d;
  // Row buffer receiving the current row; buffers are used round-robin by row.
  logic [SelWidth-1:0] sel_q, sel_d;
  // sel_q captured at the last accepted pixel, used to order the read-back rows.
  logic [SelWidth-1:0] rsel_q;

  logic valid_q, valid_d;
  logic size_err_q, size_err_d;

  logic [DataWidth-1:0]                             pix_q;
  logic [FilterSize-1:0][NumBuf-1:0][DataWidth-1:0] win_q;
  logic [FilterSize-1:0][DataWidth-1:0]             new_col;
  logic [NumBuf-1:0][DataWidth-1:0]                 rdata;

  logic size_ok, start_ok, accept, last_col, last_pix, win_pos;

  assign size_ok  = (img_size >= MinSize) && (img_size <= MaxSize);
  assign start_ok = (state_q == StIdle) && buf_start && size_ok;
  assign accept   = pixel_valid && ((state_q == StFill) || (state_q == StStream));
  assign last_col = (col_q == size_q - CntOne);
  assign last_pix = last_col && (row_q == size_q - CntOne);

  // FSM: state register
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = StFill;
      StFill:   if (accept && (row_q == FirstWin) && (col_q == FillEnd)) state_d = StStream;
      StStream: if (accept && last_pix) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy         = (state_q != StIdle);
    frame_done   = (state_q == StDone);
    window_valid = valid_q;
    size_err     = size_err_q;
  end

  always_comb begin
    size_d = size_q;
    row_d  = row_q;
    col_d  = col_q;
    sel_d  = sel_q;
    if (start_ok) begin
      size_d = img_size;
      row_d  = '0;
      col_d  = '0;
      sel_d  = '0;
    end else if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + CntOne;
        sel_d = (sel_q == SelLast) ? '0 : sel_q + SelOne;
      end else begin
        col_d = col_q + CntOne;
      end
    end
  end

  always_comb begin
    win_pos = (row_q >= FirstWin) && (col_q >= FirstWin);
`ifdef CONV_WINDOW_STRIDE2_EN
    win_pos = win_pos && (row_q[0] == FirstWin[0]) && (col_q[0] == FirstWin[0]);
`endif
    valid_d    = accept && win_pos;
    size_err_d = (state_q == StIdle) && buf_start && !size_ok;
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      size_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      size_q     <= size_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      size_err_q <= size_err_d;
    end
  end

  // All buffers are read at the current column on every accepted pixel; only the
  // one owning the current row is written.
  for (genvar b = 0; b < NumBuf; b++) begin : g_row
    conv_linebuf_row #(
      .DataWidth (DataWidth),
      .Depth     (MaxWidth),
      .AddrWidth (AddrWidth)
    ) u_row (
      .clk     (clk),
      .xrst    (xrst),
      .en_i    (accept),
      .we_i    (accept && (sel_q == SelWidth'(b))),
      .addr_i  (col_q[AddrWidth-1:0]),
      .wdata_i (pixel_in),
      .rdata_o (rdata[b])
    );
  end

  // Newest window column is formed from the RAM read registers and the registered
  // pixel, so it appears one cycle after acceptance without an extra pipeline stage.
  // The buffer just written returned the oldest row; the others follow in rotation.
  always_comb begin
    logic [SelWidth-1:0] idx;
    idx     = '0;
    new_col = '0;
    for (int i = 0; i < int'(NumBuf); i++) begin
      idx        = SelWidth'((int'(rsel_q) + i) % int'(NumBuf));
      new_col[i] = rdata[idx];
    end
    new_col[FilterSize-1] = pix_q;
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      win_q  <= '0;
      pix_q  <= '0;
      rsel_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < int'(FilterSize); i++) begin
        for (int j = 0; j < int'(NumBuf) - 1; j++) begin
          win_q[i][j] <= win_q[i][j+1];
        end
        win_q[i][NumBuf-1] <= new_col[i];
      end
      pix_q  <= pixel_in;
      rsel_q <= sel_q;
    end
  end

  always_comb begin
    pixel_out = '0;
    for (int i = 0; i < int'(FilterSize); i++) begin
      for (int j = 0; j < int'(NumBuf); j++) begin
        pixel_out[i*FilterSize + j] = win_q[i][j];
      end
      pixel_out[i*FilterSize + NumBuf] = new_col[i];
    end
  end

endmodule

// File: tb/tb_conv_window.sv
module tb_conv_window;

  localparam int unsigned DW   = 16;
  localparam int unsigned LW   = 6;
  localparam int unsigned MAXW = 32;

  logic clk = 1'b0;
  logic xrst;
  always #5 clk = ~clk;

  logic            start3, pv3, wv3, fd3, se3, busy3;
  logic [LW-1:0]   size3;
  logic [DW-1:0]   pin3;
  logic [8:0][DW-1:0] out3;

  logic            start5, pv5, wv5, fd5, se5, busy5;
  logic [LW-1:0]   size5;
  logic [DW-1:0]   pin5;
  logic [24:0][DW-1:0] out5;

  conv_window #(.DataWidth(DW), .FilterSize(3), .MaxWidth(MAXW), .CntWidth(LW)) u_dut3 (
    .clk(clk), .xrst(xrst), .buf_start(start3), .img_size(size3), .pixel_valid(pv3),
    .pixel_in(pin3), .pixel_out(out3), .window_valid(wv3), .frame_done(fd3),
    .size_err(se3), .busy(busy3)
  );

  conv_window #(.DataWidth(DW), .FilterSize(5), .MaxWidth(MAXW), .CntWidth(LW)) u_dut5 (
    .clk(clk), .xrst(xrst), .buf_start(start5), .img_size(size5), .pixel_valid(pv5),
    .pixel_in(pin5), .pixel_out(out5), .window_valid(wv5), .frame_done(fd5),
    .size_err(se5), .busy(busy5)
  );

  int checks = 0;
  int errors = 0;
  int nwin;
  logic [DW-1:0] img [MAXW*MAXW];
  logic [8:0][DW-1:0] first_win, last_win;
  int first_exp[9];
  int last_exp[9];

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [399:0] win9(input int v[9]);
    logic [8:0][DW-1:0] w;
    for (int k = 0; k < 9; k++) w[k] = DW'(v[k]);
    return 400'(w);
  endfunction

  // A window exists at every (r,c) with a full FxF neighbourhood above/left of it.
  function automatic bit is_win(input int r, input int c, input int f);
    if (r < f - 1 || c < f - 1) return 1'b0;
`ifdef CONV_WINDOW_STRIDE2_EN
    return (((r - f + 1) % 2) == 0) && (((c - f + 1) % 2) == 0);
`else
    return 1'b1;
`endif
  endfunction

  // One frame on the FSIZE=3 instance, checked pixel by pixel against the image.
  task automatic run_frame3(input int size, input int gap_pct, input bit rand_pix,
                            input bit poke, output int nwin_o);
    int k, r, c, total;
    bit v, ev, have_held;
    logic [8:0][DW-1:0] exp_w, held_w;
    total = size * size;
    nwin_o = 0;
    k = 0;
    r = 0;
    c = 0;
    have_held = 1'b0;
    held_w = '0;
    start3 = 1'b1;
    size3 = LW'(size);
    @(posedge clk); #1;
    start3 = 1'b0;
    chk_bit("start_busy", busy3, 1'b1);
    chk_bit("start_no_size_err", se3, 1'b0);
    while (k < total) begin
      v = ($urandom_range(99) >= gap_pct);
      pv3 = v;
      pin3 = rand_pix ? DW'($urandom) : DW'(k);
      if (poke) begin
        start3 = ($urandom_range(3) == 0);
        size3 = LW'(2);
      end
      if (v) img[k] = pin3;
      @(posedge clk); #1;
      pv3 = 1'b0;
      start3 = 1'b0;
      ev = 1'b0;
      if (v) begin
        r = k / size;
        c = k % size;
        ev = is_win(r, c, 3);
      end
      chk_bit("window_valid", wv3, ev);
      chk_bit("frame_done", fd3, v && (k == total - 1));
      chk_bit("busy_in_frame", busy3, 1'b1);
      chk_bit("no_size_err_in_frame", se3, 1'b0);
      if (ev) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_w[i*3+j] = img[(r - 2 + i) * size + (c - 2 + j)];
        chk_vec("window_data", 400'(out3), 400'(exp_w));
        if (nwin_o == 0) first_win = out3;
        last_win = out3;
        nwin_o++;
        held_w = exp_w;
        have_held = 1'b1;
      end else if (v) begin
        have_held = 1'b0;
      end else if (have_held) begin
        chk_vec("window_hold", 400'(out3), 400'(held_w));
      end
      if (v) k++;
    end
    @(posedge clk); #1;
    chk_bit("idle_busy", busy3, 1'b0);
    chk_bit("idle_frame_done", fd3, 1'b0);
    chk_bit("idle_window_valid", wv3, 1'b0);
  endtask

  task automatic bad_size3(input int size);
    start3 = 1'b1;
    size3 = LW'(size);
    @(posedge clk); #1;
    start3 = 1'b0;
    chk_bit("bad_size_err", se3, 1'b1);
    chk_bit("bad_size_busy", busy3, 1'b0);
    for (int k = 0; k < 16; k++) begin
      pv3 = 1'b1;
      pin3 = DW'(k);
      @(posedge clk); #1;
      chk_bit("bad_size_err_once", se3, 1'b0);
      chk_bit("bad_no_window", wv3, 1'b0);
      chk_bit("bad_busy", busy3, 1'b0);
    end
    pv3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0][DW-1:0] exp5;
    xrst = 1'b1;
    start3 = 1'b0; pv3 = 1'b0; size3 = '0; pin3 = '0;
    start5 = 1'b0; pv5 = 1'b0; size5 = '0; pin5 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_vec("reset_pixel_out3", 400'(out3), 400'(0));
    chk_vec("reset_pixel_out5", 400'(out5), 400'(0));
    chk_bit("reset_window_valid", wv3, 1'b0);
    chk_bit("reset_frame_done", fd3, 1'b0);
    chk_bit("reset_size_err", se3, 1'b0);
    chk_bit("reset_busy", busy3, 1'b0);
    chk_bit("reset_busy5", busy5, 1'b0);
    xrst = 1'b0;
    @(posedge clk); #1;

    // 4x4 frame of 0..15
    first_exp = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    last_exp  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    run_frame3(4, 0, 1'b0, 1'b0, nwin);
`ifdef CONV_WINDOW_STRIDE2_EN
    chk_int("frame4_window_count", nwin, 1);
    chk_vec("frame4_first_window", 400'(first_win), win9(first_exp));
`else
    chk_int("frame4_window_count", nwin, 4);
    chk_vec("frame4_first_window", 400'(first_win), win9(first_exp));
    chk_vec("frame4_last_window", 400'(last_win), win9(last_exp));
`endif

    // FSIZE=5, 5x5 frame: a single window equal to the whole image
    start5 = 1'b1;
    size5 = LW'(5);
    @(posedge clk); #1;
    start5 = 1'b0;
    for (int k = 0; k < 25; k++) exp5[k] = DW'(k);
    for (int k = 0; k < 25; k++) begin
      pv5 = 1'b1;
      pin5 = DW'(k);
      @(posedge clk); #1;
      chk_bit("f5_window_valid", wv5, k == 24);
      chk_bit("f5_frame_done", fd5, k == 24);
      if (k == 24) chk_vec("f5_window_data", 400'(out5), 400'(exp5));
    end
    pv5 = 1'b0;
    @(posedge clk); #1;
    chk_bit("f5_idle_busy", busy5, 1'b0);
    chk_bit("f5_idle_done", fd5, 1'b0);
    chk_bit("f5_no_size_err", se5, 1'b0);

    // Illegal sizes
    bad_size3(2);
    bad_size3(int'(MAXW) + 1);

    // Random gaps and data, 6x6, with illegal buf_start pokes mid-frame
    run_frame3(6, 50, 1'b1, 1'b1, nwin);
`ifdef CONV_WINDOW_STRIDE2_EN
    chk_int("frame6_window_count", nwin, 4);
`else
    chk_int("frame6_window_count", nwin, 16);
`endif

    // Asynchronous abort after 7 pixels
    start3 = 1'b1;
    size3 = LW'(4);
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      pv3 = 1'b1;
      pin3 = DW'(k + 100);
      @(posedge clk); #1;
    end
    pv3 = 1'b0;
    #2;
    xrst = 1'b1;
    #1;
    chk_vec("abort_pixel_out", 400'(out3), 400'(0));
    chk_bit("abort_window_valid", wv3, 1'b0);
    chk_bit("abort_busy", busy3, 1'b0);
    chk_bit("abort_frame_done", fd3, 1'b0);
    @(posedge clk); #1;
    xrst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_bit("abort_no_frame_done", fd3, 1'b0);
    end
    run_frame3(4, 0, 1'b0, 1'b0, nwin);
`ifdef CONV_WINDOW_STRIDE2_EN
    chk_int("reframe_window_count", nwin, 1);
    chk_vec("reframe_first_window", 400'(first_win), win9(first_exp));
`else
    chk_int("reframe_window_count", nwin, 4);
    chk_vec("reframe_first_window", 400'(first_win), win9(first_exp));
    chk_vec("reframe_last_window", 400'(last_win), win9(last_exp));
`endif

`ifdef CONV_WINDOW_STRIDE2_EN
    // Stride 2 on a 5x5 frame: windows at (2,2),(2,4),(4,2),(4,4)
    first_exp = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    run_frame3(5, 0, 1'b0, 1'b0, nwin);
    chk_int("stride2_window_count", nwin, 4);
    chk_vec("stride2_first_window", 400'(first_win), win9(first_exp));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
